// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and defaults for the bit-serial subtractor.
//   sub_state_t   : control FSM states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   One-bit combinational full-subtractor cell: d = a - b - bin.
//   a    (in)  : minuend bit
//   b    (in)  : subtrahend bit
//   bin  (in)  : borrow-in
//   d    (out) : difference bit
//   bout (out) : borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when a == b and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor computing a - b LSB-first,
//   one bit per clock through a single full_subtractor cell.
//   clk      (in)  : clock, rising edge
//   rst      (in)  : asynchronous active-high reset
//   start    (in)  : operation request, honoured in IDLE or DONE only
//   a, b     (in)  : minuend / subtrahend, captured on an accepted start
//   busy     (out) : high while bits are being processed
//   done     (out) : one-cycle pulse when results update
//   diff     (out) : a - b mod 2^WIDTH, held until the next completion
//   borrow   (out) : unsigned borrow-out (a < b)
//   overflow (out) : signed overflow of a - b
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, sr_q, sr_d;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bf_q, a_msb_q, b_msb_q;
    logic             borrow_q, overflow_q;
    logic             load, last;
    logic             cell_d, cell_bo;

    // A new operation may be loaded straight out of DONE for back-to-back use.
    assign load = start && ((state_q == IDLE) || (state_q == DONE));
    assign last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    full_subtractor u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (bf_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // Result shift register fills from the MSB so the LSB ends up at bit 0.
    assign sr_d = {cell_d, sr_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q       <= '0;
            sb_q       <= '0;
            sr_q       <= '0;
            bf_q       <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (load) begin
            sa_q    <= a;
            sb_q    <= b;
            bf_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == SHIFT) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            sr_q  <= sr_d;
            bf_q  <= cell_bo;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                // The final bit is still on the cell output, so publish sr_d.
                diff_q     <= sr_d;
                borrow_q   <= cell_bo;
                // Signed overflow: operand signs differ and result sign != a's.
                overflow_q <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
            end
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule
